// File: rtl/serial_fir_mac_scheduler.sv
// Control sequencer for one shared serial FIR datapath. It grants channel sample requests
// round-robin, steps the taps through the MAC, waits out the pipeline, then hands off the result.
module serial_fir_mac_scheduler #(
  parameter int unsigned NUM_CH   = 4,
  parameter int unsigned NUM_TAPS = 8,
  parameter int unsigned PIPE_LAT = 2,
  localparam int unsigned CH_W    = $clog2(NUM_CH),
  localparam int unsigned TAP_W   = $clog2(NUM_TAPS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clk_enable,
  input  logic [NUM_CH-1:0] in_valid,
  output logic [NUM_CH-1:0] in_ready,
  output logic              shift_en,
  output logic [CH_W-1:0]   shift_ch,
  output logic              mac_en,
  output logic              mac_first,
  output logic [TAP_W-1:0]  tap_idx,
  output logic [CH_W-1:0]   mac_ch,
  output logic              out_valid,
  output logic [CH_W-1:0]   out_ch,
  input  logic              out_ready,
  output logic              busy
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StMac   = 2'd1;
  localparam logic [1:0] StDrain = 2'd2;
  localparam logic [1:0] StDone  = 2'd3;

  localparam logic [TAP_W-1:0] TapLast   = TAP_W'(NUM_TAPS - 1);
  localparam logic [2:0]       DrainLast = 3'(PIPE_LAT == 0 ? 0 : PIPE_LAT - 1);
  localparam logic [CH_W:0]    NumChW    = (CH_W + 1)'(NUM_CH);

  logic [1:0]       state_q, state_d;
  logic [TAP_W-1:0] tap_q, tap_d;
  logic [2:0]       drain_q, drain_d;
  logic [CH_W-1:0]  rr_q, rr_d;
  logic [CH_W-1:0]  mac_ch_q, mac_ch_d;
  logic [CH_W-1:0]  out_ch_q, out_ch_d;
  logic             out_valid_q, out_valid_d;

  logic [CH_W:0]    cand;
  logic [CH_W-1:0]  winner;
  logic             any_req;
  logic             active;
  logic             accept;

  // Search from rr_q+1 with wrap; walking downward lets the nearest requester win last.
  always_comb begin
    cand    = '0;
    winner  = '0;
    any_req = 1'b0;
    for (int i = NUM_CH; i >= 1; i--) begin
      cand = {1'b0, rr_q} + (CH_W + 1)'(i);
      if (cand >= NumChW) cand = cand - NumChW;
      if (in_valid[cand[CH_W-1:0]]) begin
        winner  = cand[CH_W-1:0];
        any_req = 1'b1;
      end
    end
  end

  // Combinational strobes are also masked by reset so nothing is issued while it is held.
  assign active    = clk_enable & reset;
  assign accept    = (state_q == StIdle) && active && any_req;
  assign in_ready  = accept ? (NUM_CH'(1) << winner) : '0;
  assign shift_en  = accept;
  assign shift_ch  = accept ? winner : '0;
  assign mac_en    = (state_q == StMac) && active;
  assign mac_first = mac_en && (tap_q == '0);
  assign tap_idx   = tap_q;
  assign mac_ch    = mac_ch_q;
  assign out_valid = out_valid_q;
  assign out_ch    = out_ch_q;
  assign busy      = (state_q != StIdle);

  always_comb begin
    state_d     = state_q;
    tap_d       = tap_q;
    drain_d     = drain_q;
    rr_d        = rr_q;
    mac_ch_d    = mac_ch_q;
    out_ch_d    = out_ch_q;
    out_valid_d = out_valid_q;
    case (state_q)
      StIdle: begin
        if (any_req) begin
          state_d  = StMac;
          tap_d    = '0;
          rr_d     = winner;
          mac_ch_d = winner;
        end
      end
      StMac: begin
        if (tap_q == TapLast) begin
          tap_d   = '0;
          drain_d = '0;
          if (PIPE_LAT == 0) begin
            state_d     = StDone;
            out_valid_d = 1'b1;
            out_ch_d    = mac_ch_q;
          end else begin
            state_d = StDrain;
          end
        end else begin
          tap_d = tap_q + TAP_W'(1);
        end
      end
      StDrain: begin
        if (drain_q == DrainLast) begin
          state_d     = StDone;
          drain_d     = '0;
          out_valid_d = 1'b1;
          out_ch_d    = mac_ch_q;
        end else begin
          drain_d = drain_q + 3'd1;
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d     = StIdle;
          out_valid_d = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      tap_q       <= '0;
      drain_q     <= '0;
      rr_q        <= CH_W'(NUM_CH - 1);
      mac_ch_q    <= '0;
      out_ch_q    <= '0;
      out_valid_q <= 1'b0;
    end else if (clk_enable) begin
      state_q     <= state_d;
      tap_q       <= tap_d;
      drain_q     <= drain_d;
      rr_q        <= rr_d;
      mac_ch_q    <= mac_ch_d;
      out_ch_q    <= out_ch_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_serial_fir_mac_scheduler.sv
// Directed bench for serial_fir_mac_scheduler: a scoreboard queue holds the channel tag expected
// for each accepted sample and is drained on every completed output handshake.
module tb_serial_fir_mac_scheduler;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       clk_enable = 1'b1;
  logic [3:0] in_valid = '0;
  logic [3:0] in_ready;
  logic       shift_en;
  logic [1:0] shift_ch;
  logic       mac_en;
  logic       mac_first;
  logic [2:0] tap_idx;
  logic [1:0] mac_ch;
  logic       out_valid;
  logic [1:0] out_ch;
  logic       out_ready = 1'b0;
  logic       busy;

  // Second instance built with PIPE_LAT=0
  logic [3:0] iv0 = '0;
  logic [3:0] in_ready0;
  logic       shift_en0;
  logic [1:0] shift_ch0;
  logic       mac_en0;
  logic       mac_first0;
  logic [2:0] tap_idx0;
  logic [1:0] mac_ch0;
  logic       out_valid0;
  logic [1:0] out_ch0;
  logic       or0 = 1'b0;
  logic       busy0;

  int compared = 0;
  int mismatched = 0;
  int exp_q[$];
  int order_a[5] = '{0, 1, 2, 3, 0};
  int order_b[3] = '{1, 3, 1};

  serial_fir_mac_scheduler #(.NUM_CH(4), .NUM_TAPS(8), .PIPE_LAT(2)) u_dut (
    .clk(clk), .reset(reset), .clk_enable(clk_enable), .in_valid(in_valid),
    .in_ready(in_ready), .shift_en(shift_en), .shift_ch(shift_ch), .mac_en(mac_en),
    .mac_first(mac_first), .tap_idx(tap_idx), .mac_ch(mac_ch), .out_valid(out_valid),
    .out_ch(out_ch), .out_ready(out_ready), .busy(busy)
  );

  serial_fir_mac_scheduler #(.NUM_CH(4), .NUM_TAPS(8), .PIPE_LAT(0)) u_dut0 (
    .clk(clk), .reset(reset), .clk_enable(clk_enable), .in_valid(iv0),
    .in_ready(in_ready0), .shift_en(shift_en0), .shift_ch(shift_ch0), .mac_en(mac_en0),
    .mac_first(mac_first0), .tap_idx(tap_idx0), .mac_ch(mac_ch0), .out_valid(out_valid0),
    .out_ch(out_ch0), .out_ready(or0), .busy(busy0)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change 2 ns after the rising edge; checks follow 1 ns later.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_grant(input int ch, input bit push);
    int n = 0;
    #1;
    while (in_ready == '0 && n < 40) begin
      tick();
      #1;
      n++;
    end
    check("grant", 32'(in_ready), 32'(1) << ch);
    check("shift_en", 32'(shift_en), 1);
    check("shift_ch", 32'(shift_ch), ch);
    if (push) exp_q.push_back(ch);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 60) begin
      tick();
      n++;
    end
    check("idle", 32'(busy), 0);
  endtask

  always @(negedge clk) begin
    if (reset && clk_enable && out_valid && out_ready) begin
      compared++;
      assert (exp_q.size() > 0) else begin
        mismatched++;
        $error("FAIL sb_pop: observed out_ch %0h with empty queue, expected no result", out_ch);
      end
      if (exp_q.size() > 0) check("sb_out_ch", 32'(out_ch), exp_q.pop_front());
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held with random inputs
    for (int i = 0; i < 3; i++) begin
      tick();
      in_valid   = 4'($urandom);
      out_ready  = 1'($urandom);
      clk_enable = 1'($urandom);
      #1;
      check("rst_in_ready", 32'(in_ready), 0);
      check("rst_shift", 32'({shift_en, shift_ch}), 0);
      check("rst_mac", 32'({mac_en, mac_first, tap_idx, mac_ch}), 0);
      check("rst_out", 32'({out_valid, out_ch, busy}), 0);
    end
    tick();
    clk_enable = 1'b1;
    out_ready  = 1'b0;
    reset      = 1'b1;
    in_valid   = 4'b0001;
    wait_grant(0, 1'b1);
    tick();
    in_valid  = '0;
    out_ready = 1'b1;
    wait_idle();

    // Single frame on channel 2, accepted in cycle T
    out_ready = 1'b0;
    in_valid  = 4'b0100;
    wait_grant(2, 1'b1);
    tick();
    in_valid = '0;
    for (int k = 0; k < 8; k++) begin
      #1;
      check("frame_mac_en", 32'(mac_en), 1);
      check("frame_tap", 32'(tap_idx), k);
      check("frame_first", 32'(mac_first), (k == 0) ? 1 : 0);
      check("frame_mac_ch", 32'(mac_ch), 2);
      tick();
    end
    for (int k = 0; k < 2; k++) begin
      #1;
      check("drain_mac_en", 32'(mac_en), 0);
      check("drain_out_valid", 32'(out_valid), 0);
      tick();
    end
    #1;
    check("frame_out_valid", 32'(out_valid), 1);
    check("frame_out_ch", 32'(out_ch), 2);
    out_ready = 1'b1;
    tick();
    #1;
    check("frame_back_idle", 32'({busy, out_valid}), 0);

    // Backpressure in DONE
    out_ready = 1'b0;
    in_valid  = 4'b0010;
    wait_grant(1, 1'b1);
    tick();
    in_valid = 4'b1111;
    begin
      int n = 0;
      #1;
      while (!out_valid && n < 40) begin
        tick();
        #1;
        n++;
      end
    end
    check("bp_out_valid", 32'(out_valid), 1);
    for (int i = 0; i < 20; i++) begin
      tick();
      #1;
      check("bp_hold_valid", 32'(out_valid), 1);
      check("bp_hold_ch", 32'(out_ch), 1);
      check("bp_in_ready", 32'(in_ready), 0);
    end
    out_ready = 1'b1;
    tick();
    #1;
    check("bp_next_grant", 32'(in_ready), 32'(4'b0100));
    wait_grant(2, 1'b1);
    tick();
    in_valid = '0;
    wait_idle();

    // Freeze at tap 3 for five edges
    in_valid = 4'b0001;
    wait_grant(0, 1'b1);
    tick();
    in_valid = '0;
    for (int k = 0; k < 3; k++) tick();
    #1;
    check("ce_tap3", 32'(tap_idx), 3);
    clk_enable = 1'b0;
    #1;
    check("ce_mac_off", 32'(mac_en), 0);
    for (int k = 0; k < 5; k++) begin
      tick();
      #1;
      check("ce_tap_hold", 32'(tap_idx), 3);
      check("ce_mac_hold", 32'(mac_en), 0);
    end
    clk_enable = 1'b1;
    #1;
    check("ce_resume", 32'({mac_en, tap_idx}), 32'({1'b1, 3'd3}));
    for (int k = 4; k < 8; k++) begin
      tick();
      #1;
      check("ce_tap", 32'(tap_idx), k);
    end
    for (int k = 0; k < 2; k++) begin
      tick();
      #1;
      check("ce_no_valid", 32'(out_valid), 0);
    end
    tick();
    #1;
    check("ce_out_valid", 32'(out_valid), 1);
    tick();
    wait_idle();

    // Reset mid-frame abandons it
    in_valid = 4'b0010;
    wait_grant(1, 1'b0);
    tick();
    in_valid = '0;
    for (int k = 0; k < 5; k++) tick();
    #1;
    check("mr_tap5", 32'(tap_idx), 5);
    reset = 1'b0;
    #1;
    check("mr_reset", 32'({busy, mac_en, tap_idx}), 0);
    tick();
    reset = 1'b1;
    for (int k = 0; k < 15; k++) begin
      tick();
      #1;
      check("mr_no_valid", 32'(out_valid), 0);
    end

    // Fairness; the first grant also shows rr_ptr returned to NUM_CH-1
    out_ready = 1'b1;
    in_valid  = 4'b1111;
    foreach (order_a[i]) begin
      wait_grant(order_a[i], 1'b1);
      tick();
    end
    in_valid = 4'b1010;
    foreach (order_b[i]) begin
      wait_grant(order_b[i], 1'b1);
      tick();
    end
    in_valid = '0;
    wait_idle();

    // PIPE_LAT=0 instance
    iv0 = 4'b0001;
    #1;
    check("p0_grant", 32'(in_ready0), 32'(4'b0001));
    tick();
    iv0 = '0;
    for (int k = 0; k < 8; k++) begin
      #1;
      check("p0_mac", 32'({mac_en0, tap_idx0, out_valid0}), 32'({1'b1, 3'(k), 1'b0}));
      tick();
    end
    #1;
    check("p0_out_valid", 32'(out_valid0), 1);
    check("p0_out_ch", 32'(out_ch0), 0);
    or0 = 1'b1;
    tick();
    #1;
    check("p0_idle", 32'({busy0, out_valid0}), 0);

    check("sb_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
